// File: rtl/packet_pkg.sv
// Shared state encoding and size helpers for the packet builder.
package packet_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2,
        TAIL = 2'd3
    } state_e;

    // Number of whole output beats filled by the combined header.
    function automatic int unsigned calc_full(input int unsigned w, input int unsigned a,
                                              input int unsigned b);
        return (a + b) / w;
    endfunction

    // Header bytes left over after the whole header beats.
    function automatic int unsigned calc_off(input int unsigned w, input int unsigned a,
                                             input int unsigned b);
        return (a + b) % w;
    endfunction

    // Header beat counter width, never narrower than one bit.
    function automatic int unsigned calc_cnt_w(input int unsigned full);
        return (full == 0) ? 1 : (($clog2(full + 1) < 1) ? 1 : $clog2(full + 1));
    endfunction

endpackage

// File: rtl/packet_builder_merge.sv
// Joins the carried header/payload residue with the incoming payload beat.
module packet_builder_merge
    import packet_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned OFF   = 2,
    parameter int unsigned RES_W = (OFF == 0) ? 1 : OFF
) (
    input  logic [RES_W*8-1:0] res_data,
    input  logic [W*8-1:0]     in_data,
    input  logic [W-1:0]       in_byteen,
    output logic [W*8-1:0]     merged_data_c,
    output logic [W-1:0]       merged_byteen_c,
    output logic [RES_W*8-1:0] next_res_data_c,
    output logic [RES_W-1:0]   next_res_be_c,
    output logic               overflow_c
);

    if (OFF == 0) begin : g_pass
        // Header ends on a beat boundary: payload passes straight through.
        logic unused_res;
        assign unused_res      = ^res_data;
        assign merged_data_c   = in_data;
        assign merged_byteen_c = in_byteen;
        assign next_res_data_c = '0;
        assign next_res_be_c   = '0;
        assign overflow_c      = 1'b0;
    end else begin : g_merge
        // Residue occupies the leading lanes; the low input lanes carry to the next beat.
        assign merged_data_c   = {res_data, in_data[W*8-1 -: (W-OFF)*8]};
        assign merged_byteen_c = {{OFF{1'b1}}, in_byteen[W-1 -: (W-OFF)]};
        assign next_res_data_c = in_data[OFF*8-1:0];
        assign next_res_be_c   = in_byteen[OFF-1:0];
        assign overflow_c      = |in_byteen[OFF-1:0];
    end

endmodule

// File: rtl/packet_builder.sv
// Prepends headerA/headerB to a payload stream and realigns payload across beats.
module packet_builder
    import packet_pkg::*;
#(
    parameter int unsigned WIDTH_DATA_BYTES  = 8,
    parameter int unsigned WIDTH_HDR_A_BYTES = 6,
    parameter int unsigned WIDTH_HDR_B_BYTES = 4
) (
    input  logic                            clk_host,
    input  logic                            rst_n,
    input  logic                            bus_in_valid,
    output logic                            bus_in_ready,
    input  logic                            bus_in_sop,
    input  logic                            bus_in_eop,
    input  logic [WIDTH_DATA_BYTES-1:0]     bus_in_byteen,
    input  logic [WIDTH_DATA_BYTES*8-1:0]   bus_in_data,
    input  logic [WIDTH_HDR_A_BYTES*8-1:0]  headerA,
    input  logic [WIDTH_HDR_B_BYTES*8-1:0]  headerB,
    output logic                            bus_out_valid,
    input  logic                            bus_out_ready,
    output logic                            bus_out_sop,
    output logic                            bus_out_eop,
    output logic [WIDTH_DATA_BYTES-1:0]     bus_out_byteen,
    output logic [WIDTH_DATA_BYTES*8-1:0]   bus_out_data
);

    localparam int unsigned W         = WIDTH_DATA_BYTES;
    localparam int unsigned HDR_BYTES = WIDTH_HDR_A_BYTES + WIDTH_HDR_B_BYTES;
    localparam int unsigned FULL      = calc_full(W, WIDTH_HDR_A_BYTES, WIDTH_HDR_B_BYTES);
    localparam int unsigned OFF       = calc_off(W, WIDTH_HDR_A_BYTES, WIDTH_HDR_B_BYTES);
    localparam int unsigned RES_W     = (OFF == 0) ? 1 : OFF;
    localparam int unsigned CNT_W     = calc_cnt_w(FULL);
    // Header shift register padded by one beat so its top beat is always defined.
    localparam int unsigned SR_BYTES  = HDR_BYTES + W;

    state_e                 state_q, state_d;
    logic [SR_BYTES*8-1:0]  hdr_sr_q, hdr_sr_d;
    logic [CNT_W-1:0]       beat_cnt_q, beat_cnt_d;
    logic [RES_W*8-1:0]     residue_q, residue_d;
    logic [RES_W-1:0]       residue_be_q, residue_be_d;
    logic                   sop_pend_q, sop_pend_d;

    logic [SR_BYTES*8-1:0]  hdr_load_c;
    logic [SR_BYTES*8-1:0]  hdr_shift_c;
    logic [W*8-1:0]         merged_data_c;
    logic [W-1:0]           merged_byteen_c;
    logic [RES_W*8-1:0]     next_res_data_c;
    logic [RES_W-1:0]       next_res_be_c;
    logic                   overflow_c;

    assign hdr_load_c  = {headerA, headerB, {(W*8){1'b0}}};
    assign hdr_shift_c = hdr_sr_q << (W*8);

    // Residue/payload lane merge.
    packet_builder_merge #(
        .W     (W),
        .OFF   (OFF),
        .RES_W (RES_W)
    ) u_merge (
        .res_data        (residue_q),
        .in_data         (bus_in_data),
        .in_byteen       (bus_in_byteen),
        .merged_data_c   (merged_data_c),
        .merged_byteen_c (merged_byteen_c),
        .next_res_data_c (next_res_data_c),
        .next_res_be_c   (next_res_be_c),
        .overflow_c      (overflow_c)
    );

    // State and datapath registers.
    always_ff @(posedge clk_host or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            hdr_sr_q     <= '0;
            beat_cnt_q   <= '0;
            residue_q    <= '0;
            residue_be_q <= '0;
            sop_pend_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            hdr_sr_q     <= hdr_sr_d;
            beat_cnt_q   <= beat_cnt_d;
            residue_q    <= residue_d;
            residue_be_q <= residue_be_d;
            sop_pend_q   <= sop_pend_d;
        end
    end

    // Next-state and output decode; outputs stay zero whenever no beat is offered.
    always_comb begin
        state_d        = state_q;
        hdr_sr_d       = hdr_sr_q;
        beat_cnt_d     = beat_cnt_q;
        residue_d      = residue_q;
        residue_be_d   = residue_be_q;
        sop_pend_d     = sop_pend_q;
        bus_in_ready   = 1'b0;
        bus_out_valid  = 1'b0;
        bus_out_sop    = 1'b0;
        bus_out_eop    = 1'b0;
        bus_out_byteen = '0;
        bus_out_data   = '0;

        case (state_q)
            IDLE: begin
                if (bus_in_valid && bus_in_sop) begin
                    hdr_sr_d   = hdr_load_c;
                    beat_cnt_d = '0;
                    if (FULL == 0) begin
                        state_d      = PAY;
                        residue_d    = hdr_load_c[SR_BYTES*8-1 -: RES_W*8];
                        residue_be_d = '1;
                        sop_pend_d   = 1'b1;
                    end else begin
                        state_d    = HDR;
                        sop_pend_d = 1'b0;
                    end
                end
            end
            HDR: begin
                bus_out_valid  = 1'b1;
                bus_out_data   = hdr_sr_q[SR_BYTES*8-1 -: W*8];
                bus_out_byteen = '1;
                bus_out_sop    = (beat_cnt_q == '0);
                if (bus_out_ready) begin
                    hdr_sr_d   = hdr_shift_c;
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if (beat_cnt_q == CNT_W'(FULL - 1)) begin
                        state_d      = PAY;
                        residue_d    = hdr_shift_c[SR_BYTES*8-1 -: RES_W*8];
                        residue_be_d = '1;
                    end
                end
            end
            PAY: begin
                bus_in_ready  = bus_out_ready;
                bus_out_valid = bus_in_valid;
                if (bus_in_valid) begin
                    bus_out_data   = merged_data_c;
                    bus_out_byteen = merged_byteen_c;
                    bus_out_sop    = sop_pend_q;
                    bus_out_eop    = bus_in_eop && !overflow_c;
                    if (bus_out_ready) begin
                        residue_d    = next_res_data_c;
                        residue_be_d = next_res_be_c;
                        sop_pend_d   = 1'b0;
                        if (bus_in_eop) begin
                            state_d = overflow_c ? TAIL : IDLE;
                        end
                    end
                end
            end
            TAIL: begin
                bus_out_valid  = 1'b1;
                bus_out_data   = {residue_q, {((W-RES_W)*8){1'b0}}};
                bus_out_byteen = {residue_be_q, {(W-RES_W){1'b0}}};
                bus_out_eop    = 1'b1;
                if (bus_out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_packet_builder.sv
// Directed bench for packet_builder across default, OFF=0 and FULL=0 configurations.
module tb_packet_builder;

    logic        clk_host = 1'b0;
    logic        rst_n;
    logic        in_valid, in_sop, in_eop, out_rdy;
    logic [7:0]  in_be;
    logic [63:0] in_data;
    int          sel;

    logic [47:0] ha0;  logic [31:0] hb0;
    logic [31:0] ha1;  logic [31:0] hb1;
    logic [23:0] ha2;  logic [15:0] hb2;

    logic [2:0]  iv, ir, ov, osop, oeop;
    logic [7:0]  obe [3];
    logic [63:0] od  [3];

    logic        o_valid, o_sop, o_eop, i_ready;
    logic [7:0]  o_be;
    logic [63:0] o_data;

    int tests = 0;
    int fails = 0;

    logic [63:0] vd[$];  logic [7:0] vbe[$];  bit vsop[$];  bit veop[$];
    logic [63:0] ed[$];  logic [7:0] ebe[$];  bit esop[$];  bit eeop[$];
    logic [63:0] gd[$];  logic [7:0] gbe[$];  bit gsop[$];  bit geop[$];

    always #5 clk_host = ~clk_host;

    always_comb begin
        iv = 3'b000;
        iv[sel] = in_valid;
        o_valid = ov[sel];
        o_sop   = osop[sel];
        o_eop   = oeop[sel];
        o_be    = obe[sel];
        o_data  = od[sel];
        i_ready = ir[sel];
    end

    packet_builder dut0 (
        .clk_host(clk_host), .rst_n(rst_n),
        .bus_in_valid(iv[0]), .bus_in_ready(ir[0]), .bus_in_sop(in_sop), .bus_in_eop(in_eop),
        .bus_in_byteen(in_be), .bus_in_data(in_data), .headerA(ha0), .headerB(hb0),
        .bus_out_valid(ov[0]), .bus_out_ready(out_rdy), .bus_out_sop(osop[0]),
        .bus_out_eop(oeop[0]), .bus_out_byteen(obe[0]), .bus_out_data(od[0])
    );

    packet_builder #(.WIDTH_DATA_BYTES(8), .WIDTH_HDR_A_BYTES(4), .WIDTH_HDR_B_BYTES(4)) dut1 (
        .clk_host(clk_host), .rst_n(rst_n),
        .bus_in_valid(iv[1]), .bus_in_ready(ir[1]), .bus_in_sop(in_sop), .bus_in_eop(in_eop),
        .bus_in_byteen(in_be), .bus_in_data(in_data), .headerA(ha1), .headerB(hb1),
        .bus_out_valid(ov[1]), .bus_out_ready(out_rdy), .bus_out_sop(osop[1]),
        .bus_out_eop(oeop[1]), .bus_out_byteen(obe[1]), .bus_out_data(od[1])
    );

    packet_builder #(.WIDTH_DATA_BYTES(8), .WIDTH_HDR_A_BYTES(3), .WIDTH_HDR_B_BYTES(2)) dut2 (
        .clk_host(clk_host), .rst_n(rst_n),
        .bus_in_valid(iv[2]), .bus_in_ready(ir[2]), .bus_in_sop(in_sop), .bus_in_eop(in_eop),
        .bus_in_byteen(in_be), .bus_in_data(in_data), .headerA(ha2), .headerB(hb2),
        .bus_out_valid(ov[2]), .bus_out_ready(out_rdy), .bus_out_sop(osop[2]),
        .bus_out_eop(oeop[2]), .bus_out_byteen(obe[2]), .bus_out_data(od[2])
    );

    // Stimulus/expectation builders.
    task automatic clear_q();
        vd.delete(); vbe.delete(); vsop.delete(); veop.delete();
        ed.delete(); ebe.delete(); esop.delete(); eeop.delete();
    endtask

    task automatic add_in(input logic [63:0] d, input logic [7:0] be, input bit s, input bit e);
        vd.push_back(d); vbe.push_back(be); vsop.push_back(s); veop.push_back(e);
    endtask

    task automatic add_exp(input logic [63:0] d, input logic [7:0] be, input bit s, input bit e);
        ed.push_back(d); ebe.push_back(be); esop.push_back(s); eeop.push_back(e);
    endtask

    // Drives the queued input beats into the selected DUT and records every output beat.
    task automatic run_pkt(input int n_pkts, input bit throttle);
        int idx = 0;
        int eops = 0;
        int cyc = 0;
        gd.delete(); gbe.delete(); gsop.delete(); geop.delete();
        while ((idx < vd.size() || eops < n_pkts) && cyc < 2000) begin
            @(posedge clk_host); #1;
            out_rdy  = throttle ? ($urandom_range(0, 99) >= 30) : 1'b1;
            in_valid = (idx < vd.size());
            in_data  = in_valid ? vd[idx]  : 64'h0;
            in_be    = in_valid ? vbe[idx] : 8'h0;
            in_sop   = in_valid ? vsop[idx] : 1'b0;
            in_eop   = in_valid ? veop[idx] : 1'b0;
            #1;
            if (o_valid && out_rdy) begin
                gd.push_back(o_data); gbe.push_back(o_be);
                gsop.push_back(o_sop); geop.push_back(o_eop);
                if (o_eop) eops++;
            end
            if (in_valid && i_ready) idx++;
            cyc++;
        end
        if (cyc >= 2000) begin
            tests++; fails++;
            $display("FAIL run_timeout sel=%0d got %0d eops want %0d", sel, eops, n_pkts);
        end
        @(posedge clk_host); #1;
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_be = '0; in_data = '0; out_rdy = 1'b1;
    endtask

    task automatic load_std(input logic [63:0] d2, input logic [7:0] be2);
        add_in(64'h0001020304050607, 8'hFF, 1'b1, 1'b0);
        add_in(d2, be2, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        #3;
        tests++;
        if ({ov[0], ir[0], osop[0], oeop[0]} !== 4'b0000 || obe[0] !== 8'h00 || od[0] !== 64'h0) begin
            fails++;
            $display("FAIL reset_outputs got v%b r%b s%b e%b be=%h d=%h want all zero",
                     ov[0], ir[0], osop[0], oeop[0], obe[0], od[0]);
        end
        tests++;
        if (ov !== 3'b000 || ir !== 3'b000) begin
            fails++;
            $display("FAIL reset_all_valid got ov=%b ir=%b want 000/000", ov, ir);
        end
        @(posedge clk_host); #1;
        rst_n = 1'b1;
        @(posedge clk_host); #1;
        tests++;
        if (ov[0] !== 1'b0) begin
            fails++;
            $display("FAIL idle_after_reset got valid=%b want 0", ov[0]);
        end
    endtask

    task automatic test_basic();
        sel = 0; clear_q();
        load_std(64'h08090A0B0C000000, 8'hF8);
        add_exp(64'hA0A1A2A3A4A5B0B1, 8'hFF, 1'b1, 1'b0);
        add_exp(64'hB2B3000102030405, 8'hFF, 1'b0, 1'b0);
        add_exp(64'h060708090A0B0C00, 8'hFE, 1'b0, 1'b1);
        run_pkt(1, 1'b0);
        tests++;
        if (gd.size() != ed.size()) begin
            fails++; $display("FAIL basic_count got %0d want %0d", gd.size(), ed.size());
        end
        foreach (ed[i]) begin
            tests++;
            if (i >= gd.size() || gd[i] !== ed[i] || gbe[i] !== ebe[i] || gsop[i] !== esop[i] || geop[i] !== eeop[i]) begin
                fails++;
                $display("FAIL basic_beat%0d got %h/%h s%b e%b want %h/%h s%b e%b", i,
                         (i < gd.size()) ? gd[i] : 64'h0, (i < gd.size()) ? gbe[i] : 8'h0,
                         (i < gd.size()) ? gsop[i] : 1'b0, (i < gd.size()) ? geop[i] : 1'b0,
                         ed[i], ebe[i], esop[i], eeop[i]);
            end
        end
    endtask

    task automatic build_tail();
        clear_q();
        load_std(64'h08090A0B0C0D0E0F, 8'hFF);
        add_exp(64'hA0A1A2A3A4A5B0B1, 8'hFF, 1'b1, 1'b0);
        add_exp(64'hB2B3000102030405, 8'hFF, 1'b0, 1'b0);
        add_exp(64'h060708090A0B0C0D, 8'hFF, 1'b0, 1'b0);
        add_exp(64'h0E0F000000000000, 8'hC0, 1'b0, 1'b1);
    endtask

    task automatic test_tail(input bit throttle);
        sel = 0; build_tail();
        run_pkt(1, throttle);
        tests++;
        if (gd.size() != ed.size()) begin
            fails++; $display("FAIL tail_count thr=%0b got %0d want %0d", throttle, gd.size(), ed.size());
        end
        foreach (ed[i]) begin
            tests++;
            if (i >= gd.size() || gd[i] !== ed[i] || gbe[i] !== ebe[i] || gsop[i] !== esop[i] || geop[i] !== eeop[i]) begin
                fails++;
                $display("FAIL tail_beat%0d thr=%0b got %h/%h s%b e%b want %h/%h s%b e%b", i, throttle,
                         (i < gd.size()) ? gd[i] : 64'h0, (i < gd.size()) ? gbe[i] : 8'h0,
                         (i < gd.size()) ? gsop[i] : 1'b0, (i < gd.size()) ? geop[i] : 1'b0,
                         ed[i], ebe[i], esop[i], eeop[i]);
            end
        end
    endtask

    task automatic test_off_zero();
        sel = 1; clear_q();
        load_std(64'h08090A0B0C000000, 8'hF8);
        add_exp(64'hA0A1A2A3B0B1B2B3, 8'hFF, 1'b1, 1'b0);
        add_exp(64'h0001020304050607, 8'hFF, 1'b0, 1'b0);
        add_exp(64'h08090A0B0C000000, 8'hF8, 1'b0, 1'b1);
        run_pkt(1, 1'b0);
        tests++;
        if (gd.size() != ed.size()) begin
            fails++; $display("FAIL off0_count got %0d want %0d", gd.size(), ed.size());
        end
        foreach (ed[i]) begin
            tests++;
            if (i >= gd.size() || gd[i] !== ed[i] || gbe[i] !== ebe[i] || gsop[i] !== esop[i] || geop[i] !== eeop[i]) begin
                fails++;
                $display("FAIL off0_beat%0d got %h/%h s%b e%b want %h/%h s%b e%b", i,
                         (i < gd.size()) ? gd[i] : 64'h0, (i < gd.size()) ? gbe[i] : 8'h0,
                         (i < gd.size()) ? gsop[i] : 1'b0, (i < gd.size()) ? geop[i] : 1'b0,
                         ed[i], ebe[i], esop[i], eeop[i]);
            end
        end
    endtask

    task automatic test_full_zero();
        sel = 2; clear_q();
        load_std(64'h08090A0B0C000000, 8'hF8);
        add_exp(64'hA0A1A2B0B1000102, 8'hFF, 1'b1, 1'b0);
        add_exp(64'h030405060708090A, 8'hFF, 1'b0, 1'b0);
        add_exp(64'h0B0C000000000000, 8'hC0, 1'b0, 1'b1);
        run_pkt(1, 1'b0);
        tests++;
        if (gd.size() != ed.size()) begin
            fails++; $display("FAIL full0_count got %0d want %0d", gd.size(), ed.size());
        end
        foreach (ed[i]) begin
            tests++;
            if (i >= gd.size() || gd[i] !== ed[i] || gbe[i] !== ebe[i] || gsop[i] !== esop[i] || geop[i] !== eeop[i]) begin
                fails++;
                $display("FAIL full0_beat%0d got %h/%h s%b e%b want %h/%h s%b e%b", i,
                         (i < gd.size()) ? gd[i] : 64'h0, (i < gd.size()) ? gbe[i] : 8'h0,
                         (i < gd.size()) ? gsop[i] : 1'b0, (i < gd.size()) ? geop[i] : 1'b0,
                         ed[i], ebe[i], esop[i], eeop[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        sel = 0; build_tail();
        load_std(64'h08090A0B0C000000, 8'hF8);
        add_exp(64'hA0A1A2A3A4A5B0B1, 8'hFF, 1'b1, 1'b0);
        add_exp(64'hB2B3000102030405, 8'hFF, 1'b0, 1'b0);
        add_exp(64'h060708090A0B0C00, 8'hFE, 1'b0, 1'b1);
        run_pkt(2, 1'b0);
        tests++;
        if (gd.size() != ed.size()) begin
            fails++; $display("FAIL b2b_count got %0d want %0d", gd.size(), ed.size());
        end
        foreach (ed[i]) begin
            tests++;
            if (i >= gd.size() || gd[i] !== ed[i] || gbe[i] !== ebe[i] || gsop[i] !== esop[i] || geop[i] !== eeop[i]) begin
                fails++;
                $display("FAIL b2b_beat%0d got %h/%h s%b e%b want %h/%h s%b e%b", i,
                         (i < gd.size()) ? gd[i] : 64'h0, (i < gd.size()) ? gbe[i] : 8'h0,
                         (i < gd.size()) ? gsop[i] : 1'b0, (i < gd.size()) ? geop[i] : 1'b0,
                         ed[i], ebe[i], esop[i], eeop[i]);
            end
        end
    endtask

    task automatic test_reset_mid_hdr();
        sel = 0; out_rdy = 1'b0;
        @(posedge clk_host); #1;
        in_valid = 1'b1; in_sop = 1'b1; in_eop = 1'b0;
        in_be = 8'hFF; in_data = 64'h0001020304050607;
        @(posedge clk_host); #1;
        tests++;
        if (o_valid !== 1'b1 || o_sop !== 1'b1 || o_data !== 64'hA0A1A2A3A4A5B0B1 || i_ready !== 1'b0) begin
            fails++;
            $display("FAIL rst_hdr_beat got v%b s%b d=%h r%b want v1 s1 d=a0a1a2a3a4a5b0b1 r0",
                     o_valid, o_sop, o_data, i_ready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (o_valid !== 1'b0 || o_data !== 64'h0 || o_be !== 8'h00 || o_eop !== 1'b0) begin
            fails++;
            $display("FAIL rst_async_drop got v%b d=%h be=%h e%b want all zero", o_valid, o_data, o_be, o_eop);
        end
        in_valid = 1'b0; in_sop = 1'b0;
        @(posedge clk_host); #1;
        rst_n = 1'b1; out_rdy = 1'b1;
        test_basic();
    endtask

    initial begin
        rst_n = 1'b0; sel = 0; out_rdy = 1'b1;
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_be = '0; in_data = '0;
        ha0 = 48'hA0A1A2A3A4A5; hb0 = 32'hB0B1B2B3;
        ha1 = 32'hA0A1A2A3;     hb1 = 32'hB0B1B2B3;
        ha2 = 24'hA0A1A2;       hb2 = 16'hB0B1;
        test_reset();
        test_basic();
        test_tail(1'b0);
        test_off_zero();
        test_full_zero();
        test_tail(1'b1);
        test_back_to_back();
        test_reset_mid_hdr();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
